// File: rtl/q_measure_pkg.sv
// Shared types and constants for the Q measurement front-end.
// Holds the FSM encoding, default timing constants and the phase-counter sizing helper.
package q_measure_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    REPORT = 2'd3
  } state_e;

  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_WINDOW_CYCLES = 16;

  // One phase counter times both SETTLE and COUNT, so it is sized for the longer phase.
  function automatic int phase_w(input int settle_cycles, input int window_cycles);
    int longest;
    longest = (settle_cycles > window_cycles) ? settle_cycles : window_cycles;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/q_measure_edge_sync.sv
// Brings the asynchronous oscillator pin into the clk domain and flags its rising edges.
// rise is a one-cycle pulse lagging the pin edge by 2-3 clk cycles.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic osc_i,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic sync3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= osc_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // sync3_q is only an edge-history flop; sync2_q is the first trustworthy sample.
  assign rise = sync2_q & ~sync3_q;

endmodule

// File: rtl/q_measure.sv
// Q measurement front-end: drives the DAC code, waits for settling, then counts oscillator
// edges over a fixed gate and reports the count with a one-cycle ready strobe.
//
// Handshake: ready is a one-cycle strobe with no back-pressure; q_measured is new and valid in
// exactly the cycle ready is high and holds its value until the next report or reset.
module q_measure
  import q_measure_pkg::*;
#(
  parameter int WIDTH         = 10,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] i_ref_setup,
  input  logic             osc_in,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] q_measured,
  output logic             ready,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int               PW          = phase_w(SETTLE_CYCLES, WINDOW_CYCLES);
  localparam logic [PW-1:0]    SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0]    WINDOW_LAST = PW'(WINDOW_CYCLES - 1);
  localparam logic [PW-1:0]    PHASE_ONE   = PW'(1);
  localparam logic [WIDTH-1:0] CODE_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE     = WIDTH'(1);

  state_e           state_q;
  logic [PW-1:0]    phase_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] dac_q;
  logic [WIDTH-1:0] q_meas_q;
  logic             ready_q;
  logic             busy_q;
  logic             rise;
  logic             retarget;

  edge_sync u_edge_sync (
    .clk   (clk),
    .rst   (rst),
    .osc_i (osc_in),
    .rise  (rise)
  );

  // Saturating edge count: a fast oscillator must pin at full scale, never wrap to a small Q.
  always_comb begin
    cnt_d = cnt_q;
    if (rise && (cnt_q != CODE_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  assign retarget = (i_ref_setup != dac_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      cnt_q    <= '0;
      dac_q    <= CODE_MAX;
      q_meas_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en) begin
            state_q <= SETTLE;
            dac_q   <= i_ref_setup;
            phase_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SETTLE, COUNT: begin
          // Enable drop outranks a retarget: leave the DAC where it is.
          if (!en) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (retarget) begin
            state_q <= SETTLE;
            dac_q   <= i_ref_setup;
            phase_q <= '0;
            cnt_q   <= '0;
          end else if (state_q == SETTLE) begin
            if (phase_q == SETTLE_LAST) begin
              state_q <= COUNT;
              phase_q <= '0;
            end else begin
              phase_q <= phase_q + PHASE_ONE;
            end
          end else begin
            cnt_q <= cnt_d;
            if (phase_q == WINDOW_LAST) begin
              // Include the edge seen in the final gate cycle in the reported value.
              state_q  <= REPORT;
              q_meas_q <= cnt_d;
              ready_q  <= 1'b1;
            end else begin
              phase_q <= phase_q + PHASE_ONE;
            end
          end
        end
        REPORT: begin
          if (en) begin
            state_q <= SETTLE;
            dac_q   <= i_ref_setup;
            phase_q <= '0;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dac_code   = dac_q;
  assign q_measured = q_meas_q;
  assign ready      = ready_q;
  assign busy       = busy_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_q_measure.sv
// Bench for q_measure: a default instance (WIDTH=10, S=4, W=16) and a narrow saturating one
// (WIDTH=3, S=4, W=32) run side by side against a timeline model of measurement start edges.
module tb_q_measure;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [9:0] i_ref;
  logic       osc;

  logic [9:0] dac_a, q_a;
  logic       rdy_a, busy_a;
  logic [1:0] st_a;
  logic [2:0] dac_b, q_b;
  logic       rdy_b, busy_b;
  logic [1:0] st_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  q_measure #(.WIDTH(10), .SETTLE_CYCLES(4), .WINDOW_CYCLES(16)) dut_a (
    .clk(clk), .rst(rst), .en(en), .i_ref_setup(i_ref), .osc_in(osc),
    .dac_code(dac_a), .q_measured(q_a), .ready(rdy_a), .busy(busy_a), .state_dbg(st_a)
  );

  q_measure #(.WIDTH(3), .SETTLE_CYCLES(4), .WINDOW_CYCLES(32)) dut_b (
    .clk(clk), .rst(rst), .en(en), .i_ref_setup(i_ref[2:0]), .osc_in(osc),
    .dac_code(dac_b), .q_measured(q_b), .ready(rdy_b), .busy(busy_b), .state_dbg(st_b)
  );

  // ---------------- reference model ----------------
  // A measurement is identified by the edge at which it was started (en/retarget/report-with-en).
  // Its report falls exactly S+W+1 edges later; the count is the number of pin rising edges the
  // synchronizer exposes over the W gate cycles, clamped at full scale.
  int cyc = -1;
  bit hist [0:8191];
  int sc  [2] = '{4, 4};
  int wc  [2] = '{16, 32};
  int mxv [2] = '{1023, 7};
  int ms  [2];
  int md  [2] = '{1023, 7};
  int mq  [2] = '{0, 0};
  bit ma  [2] = '{1'b0, 1'b0};
  bit mr  [2] = '{1'b0, 1'b0};

  function automatic int rises(input int a, input int b, input int mx);
    int k;
    k = 0;
    for (int c = a; c <= b; c++) begin
      if (c >= 2 && hist[c-1] && !hist[c-2]) k++;
    end
    return (k > mx) ? mx : k;
  endfunction

  always @(posedge clk) begin
    int ir, o;
    cyc++;
    if (rst) begin
      hist[cyc] = 1'b0;
      if (cyc > 0) hist[cyc-1] = 1'b0;
    end else begin
      hist[cyc] = osc;
    end
    for (int j = 0; j < 2; j++) begin
      ir = int'(i_ref) & mxv[j];
      mr[j] = 1'b0;
      if (rst) begin
        ma[j] = 1'b0; md[j] = mxv[j]; mq[j] = 0;
      end else if (!ma[j]) begin
        if (en) begin ma[j] = 1'b1; ms[j] = cyc; md[j] = ir; end
      end else begin
        o = cyc - 1 - ms[j];
        if (o < sc[j] + wc[j]) begin
          if (!en) ma[j] = 1'b0;
          else if (ir != md[j]) begin md[j] = ir; ms[j] = cyc; end
          else if (o == sc[j] + wc[j] - 1) begin
            mq[j] = rises(ms[j] + sc[j], cyc - 1, mxv[j]);
            mr[j] = 1'b1;
          end
        end else if (en) begin
          ms[j] = cyc; md[j] = ir;
        end else begin
          ma[j] = 1'b0;
        end
      end
    end
  end

  function automatic logic [21:0] exp_a();
    return {10'(md[0]), 10'(mq[0]), mr[0], ma[0]};
  endfunction

  function automatic logic [7:0] exp_b();
    return {3'(md[1]), 3'(mq[1]), mr[1], ma[1]};
  endfunction

  // ---------------- oscillator driver ----------------
  int osc_mode = 0;
  int osc_half = 2;
  int osc_cnt  = 0;

  task automatic drive_osc();
    case (osc_mode)
      0: osc = 1'b0;
      1: begin
        osc_cnt++;
        if (osc_cnt >= osc_half) begin osc_cnt = 0; osc = ~osc; end
      end
      default: osc = 1'($urandom_range(0, 1));
    endcase
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b0; i_ref = 10'd0; osc = 1'b0; osc_mode = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dac_a, q_a, rdy_a, busy_a, st_a} !== {10'd1023, 10'd0, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_a dac=%0d q=%0d rdy=%b busy=%b st=%0d, want 1023/0/0/0/0",
               dac_a, q_a, rdy_a, busy_a, st_a);
    end
    checks++;
    if ({dac_b, q_b, rdy_b, busy_b} !== {3'd7, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_b dac=%0d q=%0d rdy=%b busy=%b, want 7/0/0/0", dac_b, q_b, rdy_b, busy_b);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int r1, r2;
    r1 = 0; r2 = 0;
    i_ref = 10'd700; en = 1'b1; osc_mode = 1; osc_half = 2; osc_cnt = 0; osc = 1'b0;
    for (int t = 1; t <= 80; t++) begin
      @(negedge clk);
      checks++;
      if ({dac_a, q_a, rdy_a, busy_a} !== exp_a()) begin
        errors++; $display("FAIL basic_a t=%0d got=%h want=%h", t, {dac_a, q_a, rdy_a, busy_a}, exp_a());
      end
      checks++;
      if ({dac_b, q_b, rdy_b, busy_b} !== exp_b()) begin
        errors++; $display("FAIL basic_b t=%0d got=%h want=%h", t, {dac_b, q_b, rdy_b, busy_b}, exp_b());
      end
      if (t == 1) begin
        checks++;
        if (dac_a !== 10'd700) begin errors++; $display("FAIL basic_dac got=%0d want=700", dac_a); end
      end
      if (rdy_a) begin
        if (r1 == 0) begin
          r1 = t; checks++;
          if (q_a !== 10'd4) begin errors++; $display("FAIL basic_q got=%0d want=4", q_a); end
        end else if (r2 == 0) r2 = t;
      end
      if (rdy_b) begin
        checks++;
        if (q_b !== 3'd7) begin errors++; $display("FAIL basic_sat_b got=%0d want=7", q_b); end
      end
      if (t == 43) en = 1'b0;
      drive_osc();
    end
    checks++;
    if (r1 != 21 || r2 != 42) begin
      errors++; $display("FAIL basic_ready_times got=%0d,%0d want=21,42", r1, r2);
    end
  endtask

  task automatic test_saturation();
    int seen;
    seen = 0;
    i_ref = 10'($urandom_range(0, 1023)); en = 1'b1; osc_mode = 1; osc_half = 1; osc_cnt = 0;
    for (int t = 1; t <= 80; t++) begin
      @(negedge clk);
      checks++;
      if ({dac_a, q_a, rdy_a, busy_a} !== exp_a()) begin
        errors++; $display("FAIL sat_a t=%0d got=%h want=%h", t, {dac_a, q_a, rdy_a, busy_a}, exp_a());
      end
      checks++;
      if ({dac_b, q_b, rdy_b, busy_b} !== exp_b()) begin
        errors++; $display("FAIL sat_b t=%0d got=%h want=%h", t, {dac_b, q_b, rdy_b, busy_b}, exp_b());
      end
      if (rdy_b && seen == 0) begin
        seen = t; checks++;
        if (q_b !== 3'd7) begin errors++; $display("FAIL sat_q got=%0d want=7", q_b); end
      end
      if (t == 40) en = 1'b0;
      drive_osc();
    end
    checks++;
    if (seen != 37) begin errors++; $display("FAIL sat_ready_time got=%0d want=37", seen); end
  endtask

  task automatic test_retarget();
    int r1;
    r1 = 0;
    i_ref = 10'd700; en = 1'b1; osc_mode = 1; osc_half = 2; osc_cnt = 0;
    for (int t = 1; t <= 100; t++) begin
      @(negedge clk);
      checks++;
      if ({dac_a, q_a, rdy_a, busy_a} !== exp_a()) begin
        errors++; $display("FAIL retarget_a t=%0d got=%h want=%h", t, {dac_a, q_a, rdy_a, busy_a}, exp_a());
      end
      checks++;
      if ({dac_b, q_b, rdy_b, busy_b} !== exp_b()) begin
        errors++; $display("FAIL retarget_b t=%0d got=%h want=%h", t, {dac_b, q_b, rdy_b, busy_b}, exp_b());
      end
      if (t == 15) begin
        checks++;
        if (dac_a !== 10'd650) begin errors++; $display("FAIL retarget_dac got=%0d want=650", dac_a); end
      end
      if (rdy_a && r1 == 0) r1 = t;
      if (t == 14) i_ref = 10'd650;
      if (t == 60) en = 1'b0;
      drive_osc();
    end
    checks++;
    if (r1 != 35) begin errors++; $display("FAIL retarget_ready_time got=%0d want=35", r1); end
  endtask

  task automatic test_enable_drop();
    int q_hold, n_rdy;
    q_hold = mq[0]; n_rdy = 0;
    i_ref = 10'($urandom_range(0, 1023)); en = 1'b1; osc_mode = 2;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      checks++;
      if ({dac_a, q_a, rdy_a, busy_a} !== exp_a()) begin
        errors++; $display("FAIL en_drop_a t=%0d got=%h want=%h", t, {dac_a, q_a, rdy_a, busy_a}, exp_a());
      end
      if (rdy_a || rdy_b) n_rdy++;
      if (t == 2) en = 1'b0;
      drive_osc();
    end
    checks++;
    if (n_rdy != 0 || q_a !== 10'(q_hold)) begin
      errors++; $display("FAIL en_drop_hold readies=%0d q=%0d want 0 readies q=%0d", n_rdy, q_a, q_hold);
    end
  endtask

  task automatic test_reset_mid();
    int r1;
    r1 = 0;
    i_ref = 10'($urandom_range(0, 1023)); en = 1'b1; osc_mode = 1; osc_half = 2; osc_cnt = 0;
    for (int t = 1; t <= 90; t++) begin
      @(negedge clk);
      checks++;
      if ({dac_a, q_a, rdy_a, busy_a} !== exp_a()) begin
        errors++; $display("FAIL rst_mid_a t=%0d got=%h want=%h", t, {dac_a, q_a, rdy_a, busy_a}, exp_a());
      end
      checks++;
      if ({dac_b, q_b, rdy_b, busy_b} !== exp_b()) begin
        errors++; $display("FAIL rst_mid_b t=%0d got=%h want=%h", t, {dac_b, q_b, rdy_b, busy_b}, exp_b());
      end
      if (t == 13) begin
        checks++;
        if ({st_a, q_a, busy_a, dac_a} !== {2'd0, 10'd0, 1'b0, 10'd1023}) begin
          errors++; $display("FAIL rst_mid_state st=%0d q=%0d busy=%b dac=%0d want 0/0/0/1023",
                             st_a, q_a, busy_a, dac_a);
        end
        rst = 1'b0;
      end
      if (t > 13 && rdy_a && r1 == 0) r1 = t - 13;
      if (t == 12) rst = 1'b1;
      if (t == 50) en = 1'b0;
      drive_osc();
    end
    checks++;
    if (r1 != 21) begin errors++; $display("FAIL rst_mid_latency got=%0d want=21", r1); end
  endtask

  task automatic test_random();
    logic prev_a, prev_b;
    prev_a = 1'b0; prev_b = 1'b0;
    osc_mode = 2;
    for (int t = 1; t <= 1000; t++) begin
      @(negedge clk);
      checks++;
      if ({dac_a, q_a, rdy_a, busy_a} !== exp_a()) begin
        errors++; $display("FAIL random_a t=%0d got=%h want=%h", t, {dac_a, q_a, rdy_a, busy_a}, exp_a());
      end
      checks++;
      if ({dac_b, q_b, rdy_b, busy_b} !== exp_b()) begin
        errors++; $display("FAIL random_b t=%0d got=%h want=%h", t, {dac_b, q_b, rdy_b, busy_b}, exp_b());
      end
      checks++;
      if ((prev_a && rdy_a) || (prev_b && rdy_b)) begin
        errors++; $display("FAIL random_ready_twice t=%0d a=%b%b b=%b%b want no back-to-back",
                           t, prev_a, rdy_a, prev_b, rdy_b);
      end
      prev_a = rdy_a; prev_b = rdy_b;
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 59) == 0) i_ref = 10'($urandom_range(0, 1023));
      drive_osc();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_retarget();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
